// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words into instruction memory
// and holds the CPU in reset while loading. Optional checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned MAX_WORDS      = 8192,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_d,
  output logic [15:0] mem_address,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO, S_DONE, S_ERROR
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_DONE, S_ERROR
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   mem_d_q, mem_d_d;
  logic          mem_we_q, mem_we_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rx, accept;
  logic [15:0]   len_w;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [15:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    len_d      = len_q;
    addr_d     = addr_q;
    mem_d_d    = mem_d_q;
    mem_we_d   = 1'b0;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
    len_w      = {hi_q, in_data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    rx = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    in_ready = rx;
    accept   = rx && in_valid;
    timer_d  = (rx && !accept) ? timer_q + TW'(1) : '0;

    // Address steps forward the cycle after a write, stopping at the last word.
    if (mem_we_q && (addr_q != len_q - 16'd1))
      addr_d = addr_q + 16'd1;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          state_d    = S_LEN_HI;
          done_d     = 1'b0;
          error_d    = 1'b0;
          addr_d     = '0;
          cpu_hold_d = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN_HI: if (accept) begin
        hi_d    = in_data;
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_d = len_w;
        if ((len_w == 16'd0) || (32'(len_w) > MAX_WORDS)) state_d = S_ERROR;
        else                                             state_d = S_DATA_HI;
      end
      S_DATA_HI: if (accept) begin
        hi_d    = in_data;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (accept) begin
        mem_d_d  = len_w;
        mem_we_d = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d   = csum_q + len_w;
        state_d  = (addr_q == len_q - 16'd1) ? S_CSUM_HI : S_DATA_HI;
`else
        state_d  = (addr_q == len_q - 16'd1) ? S_DONE : S_DATA_HI;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM_HI: if (accept) begin
        hi_d    = in_data;
        state_d = S_CSUM_LO;
      end
      S_CSUM_LO: if (accept) begin
        state_d = (len_w == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // An accepted byte always beats a coincident timer expiry.
    if (rx && !accept && (timer_q == TW'(TIMEOUT_CYCLES - 1)))
      state_d = S_ERROR;

    if ((state_d == S_ERROR) && (state_q != S_ERROR)) begin
      error_d = 1'b1;
      timer_d = '0;
    end
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      done_d     = 1'b1;
      cpu_hold_d = 1'b0;
      timer_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      hi_q       <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      mem_d_q    <= '0;
      mem_we_q   <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      timer_q    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      mem_d_q    <= mem_d_d;
      mem_we_q   <= mem_we_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
      timer_q    <= timer_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign mem_d       = mem_d_q;
  assign mem_address = addr_q;
  assign mem_we      = mem_we_q;
  assign cpu_hold    = cpu_hold_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued by the stimulus
// and consumed by an independent write monitor; status outputs are checked directly.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] mem_d;
  logic [15:0] mem_address;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int tests = 0;
  int failed = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  frame[$];

  program_loader #(.MAX_WORDS(8192), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_d(mem_d), .mem_address(mem_address), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor: every mem_we pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_write: got addr=%h d=%h, expected no write", mem_address, mem_d);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({mem_address, mem_d} !== e) begin
          failed++;
          $display("FAIL write: got addr=%h d=%h, expected addr=%h d=%h",
                   mem_address, mem_d, e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic acc;
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      tests++;
      failed++;
      $display("FAIL accept_timeout: byte %h not accepted, expected acceptance", b);
    end
  endtask

  // Sends the bytes in frame; with gap set, in_valid drops for one cycle after each byte,
  // and a stray load_start is pulsed in the gap after byte index ls_at.
  task automatic send_frame(input bit gap, input int ls_at);
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i]);
      if (gap) begin
        in_valid = 1'b0;
        load_start = (i == ls_at);
        tick();
        load_start = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(done || error) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      tests++;
      failed++;
      $display("FAIL %s_end_timeout: got no done/error, expected one within 100 cycles", name);
    end
  endtask

  task automatic check_status(input string name, input logic d, input logic e, input logic h);
    check({name, "_done"}, 32'(done), 32'(d));
    check({name, "_error"}, 32'(error), 32'(e));
    check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
  endtask

  task automatic basic_frame();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    frame.push_back(8'hBE);
    frame.push_back(8'h01);
`endif
  endtask

  initial begin
    #2;
    check("reset_outputs", {in_ready, mem_we, cpu_hold, done, error, mem_address, mem_d[10:0]},
          32'h0);
    check("reset_mem_d", 32'(mem_d), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic load with in_valid held high
    pulse_start();
    check("basic_hold_after_start", 32'(cpu_hold), 32'h1);
    check("basic_ready", 32'(in_ready), 32'h1);
    basic_frame();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    send_frame(1'b0, -1);
    wait_end("basic");
    check_status("basic", 1'b1, 1'b0, 1'b0);
    tick();
    check("basic_ready_done", 32'(in_ready), 32'h0);

    // Gaps between bytes, with a load_start that must be ignored mid-frame
    pulse_start();
    check("gap_done_cleared", 32'(done), 32'h0);
    basic_frame();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    send_frame(1'b1, 2);
    wait_end("gap");
    check_status("gap", 1'b1, 1'b0, 1'b0);

    // Zero length
    pulse_start();
    frame = '{8'h00, 8'h00};
    send_frame(1'b0, -1);
    wait_end("len0");
    check_status("len0", 1'b0, 1'b1, 1'b1);
    repeat (3) tick();

    // Length of MAX_WORDS + 1
    pulse_start();
    frame = '{8'h20, 8'h01};
    send_frame(1'b0, -1);
    wait_end("len8193");
    check_status("len8193", 1'b0, 1'b1, 1'b1);
    repeat (3) tick();

    // Timeout after a partial word
    pulse_start();
    frame = '{8'h00, 8'h01, 8'h12};
    send_frame(1'b0, -1);
    repeat (10) tick();
    check("timeout_not_early", 32'(error), 32'h0);
    begin
      int n;
      n = 0;
      while (!error && n < 40) begin
        tick();
        n++;
      end
    end
    check_status("timeout", 1'b0, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("timeout_no_ready", 32'(in_ready), 32'h0);
      tick();
    end
    in_valid = 1'b0;

    // Asynchronous reset in the middle of a load
    pulse_start();
    exp_q.push_back({16'h0000, 16'h1234});
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_frame(1'b0, -1);
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", {in_ready, mem_we, cpu_hold, done, error, mem_address, mem_d[10:0]},
          32'h0);
    check("midreset_mem_d", 32'(mem_d), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    basic_frame();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    send_frame(1'b0, -1);
    wait_end("reload");
    check_status("reload", 1'b1, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Checksum mismatch: words are written but the CPU stays held
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h02};
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    send_frame(1'b0, -1);
    wait_end("csum_bad");
    check_status("csum_bad", 1'b0, 1'b1, 1'b1);
`endif

    repeat (3) tick();
    check("writes_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
